signed_reg_bank: RTL and testbench

SIGNED_REG_BANK -- requirements
Module: signed_reg_bank

---
 rtl/signed_reg_bank.sv | 173 +++++++++++++++++
 tb/tb_signed_reg_bank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_reg_bank.sv
// Signed register bank with a read-old dual read port, one saturating
// write/operate port, a sticky saturation flag and a sequential flush sweep
// that clears one entry per clock.
module signed_reg_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ld,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             busy,
  output logic             sat
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ACC   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  state_t           r_state;
  state_t           w_nextState;
  logic [AW-1:0]    r_idx;
  logic [AW-1:0]    w_nextIdx;
  logic             r_sat;

  logic             w_addrOk;
  logic             w_rdOkA;
  logic             w_rdOkB;
  logic             w_wrEn;
  logic             w_clamp;
  logic             w_lastIdx;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_wrData;
  logic [WIDTH:0]   w_ext;

  // When DEPTH fills the address space every index is valid; otherwise
  // indices at or above DEPTH are treated as holes.
  if ((1 << AW) == DEPTH) begin : gFullRange
    assign w_addrOk = 1'b1;
    assign w_rdOkA  = 1'b1;
    assign w_rdOkB  = 1'b1;
  end else begin : gPartialRange
    assign w_addrOk = (waddr   < AW'(DEPTH));
    assign w_rdOkA  = (raddr_a < AW'(DEPTH));
    assign w_rdOkB  = (raddr_b < AW'(DEPTH));
  end

  assign w_lastIdx = (r_idx == AW'(DEPTH - 1));

  // Writes are only honoured in IDLE; during a sweep ld is discarded.
  assign w_wrEn = ld && w_addrOk && (r_state == IDLE);

  // Compute the value the addressed entry would take, with one guard bit so
  // signed overflow can be detected and clamped.
  always_comb begin
    w_cur    = w_addrOk ? r_mem[waddr] : '0;
    w_ext    = '0;
    w_wrData = '0;
    w_clamp  = 1'b0;
    case (op)
      OP_LOAD: begin
        w_wrData = wdata;
      end
      OP_ACC, OP_SUB: begin
        if (op == OP_ACC) begin
          w_ext = {w_cur[WIDTH-1], w_cur} + {wdata[WIDTH-1], wdata};
        end else begin
          w_ext = {w_cur[WIDTH-1], w_cur} - {wdata[WIDTH-1], wdata};
        end
        if (w_ext[WIDTH] != w_ext[WIDTH-1]) begin
          w_clamp  = 1'b1;
          w_wrData = w_ext[WIDTH] ? MIN_VAL : MAX_VAL;
        end else begin
          w_wrData = w_ext[WIDTH-1:0];
        end
      end
      OP_CLEAR: begin
        w_wrData = '0;
      end
      default: begin
        w_wrData = '0;
      end
    endcase
  end

  // Next-state logic: flush starts a sweep from entry 0, and the sweep ends
  // on the edge that clears the last entry.
  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    case (r_state)
      IDLE: begin
        if (flush) begin
          w_nextState = SWEEP;
          w_nextIdx   = '0;
        end
      end
      SWEEP: begin
        if (w_lastIdx) begin
          w_nextState = IDLE;
          w_nextIdx   = '0;
        end else begin
          w_nextIdx = r_idx + AW'(1);
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextIdx   = '0;
      end
    endcase
  end

  // FSM state and sweep index registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_nextState;
      r_idx   <= w_nextIdx;
    end
  end

  // Entry storage: the sweep owns the array while active, otherwise the
  // write port updates at most one entry per edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == SWEEP) begin
      r_mem[r_idx] <= '0;
    end else if (w_wrEn) begin
      r_mem[waddr] <= w_wrData;
    end
  end

  // Sticky saturation flag: a flush start clears it even if a clamping
  // write lands on the same edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_sat <= 1'b0;
    end else if ((r_state == IDLE) && flush) begin
      r_sat <= 1'b0;
    end else if (w_wrEn && w_clamp) begin
      r_sat <= 1'b1;
    end
  end

  assign rdata_a = w_rdOkA ? r_mem[raddr_a] : '0;
  assign rdata_b = w_rdOkB ? r_mem[raddr_b] : '0;
  assign busy    = (r_state == SWEEP);
  assign sat     = r_sat;

endmodule

// File: tb/tb_signed_reg_bank.sv
// Scoreboard bench for signed_reg_bank: directed scenarios followed by random
// traffic, checked against an integer-arithmetic reference model.
module tb_signed_reg_bank;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int MAXV  = 32767;
  localparam int MINV  = -32768;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ACC   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic             clk;
  logic             clr_n;
  logic             ld;
  logic [1:0]       op;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic             flush;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic             busy;
  logic             sat;

  typedef struct {
    int          step;
    logic [15:0] expA;
    logic [15:0] expB;
    logic        expBusy;
    logic        expSat;
  } expT;

  expT sbQ[$];

  int checks = 0;
  int errors = 0;
  int stepNum = 0;

  int mMem [DEPTH];
  bit mBusy;
  int mIdx;
  bit mSat;

  signed_reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .ld      (ld),
    .op      (op),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .flush   (flush),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .busy    (busy),
    .sat     (sat)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void modelReset();
    for (int i = 0; i < DEPTH; i++) mMem[i] = 0;
    mBusy = 1'b0;
    mIdx  = 0;
    mSat  = 1'b0;
  endfunction

  // What one rising edge does to the bank, in plain integer terms.
  function automatic void modelEdge(input bit ldV, input logic [1:0] opV,
                                    input int wa, input logic [15:0] wd,
                                    input bit fl);
    int v;
    int sw;
    bit clamped;
    clamped = 1'b0;
    sw = int'($signed(wd));
    if (mBusy) begin
      mMem[mIdx] = 0;
      mIdx++;
      if (mIdx == DEPTH) begin
        mBusy = 1'b0;
        mIdx  = 0;
      end
      return;
    end
    if (ldV && (wa < DEPTH)) begin
      case (opV)
        OP_LOAD: v = sw;
        OP_ACC:  v = mMem[wa] + sw;
        OP_SUB:  v = mMem[wa] - sw;
        default: v = 0;
      endcase
      if (v > MAXV) begin
        v = MAXV;
        clamped = 1'b1;
      end else if (v < MINV) begin
        v = MINV;
        clamped = 1'b1;
      end
      mMem[wa] = v;
    end
    if (fl) begin
      mBusy = 1'b1;
      mIdx  = 0;
      mSat  = 1'b0;
    end else if (clamped) begin
      mSat = 1'b1;
    end
  endfunction

  task automatic checkOutput(input string name, input int step,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
    end
  endtask

  // Drive one cycle of inputs shortly after the edge, record what the DUT
  // must show during this cycle, then advance the model across the next edge.
  task automatic applyStimulus(input bit ldV, input logic [1:0] opV, input int wa,
                               input logic [15:0] wd, input int ra, input int rb,
                               input bit fl, input bit rstn);
    expT e;
    @(posedge clk);
    #1;
    ld      = ldV;
    op      = opV;
    waddr   = AW'(wa);
    wdata   = wd;
    raddr_a = AW'(ra);
    raddr_b = AW'(rb);
    flush   = fl;
    clr_n   = rstn;
    if (!rstn) modelReset();
    e.step    = stepNum;
    e.expA    = 16'(mMem[ra]);
    e.expB    = 16'(mMem[rb]);
    e.expBusy = mBusy;
    e.expSat  = mSat;
    sbQ.push_back(e);
    stepNum++;
    if (!rstn) modelReset();
    else modelEdge(ldV, opV, wa, wd, fl);
  endtask

  task automatic idle(input int ra, input int rb);
    applyStimulus(1'b0, OP_LOAD, 0, 16'h0000, ra, rb, 1'b0, 1'b1);
  endtask

  // Monitor: compares every recorded expectation against the DUT mid-cycle.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("rdata_a", e.step, 32'(rdata_a), 32'(e.expA));
        checkOutput("rdata_b", e.step, 32'(rdata_b), 32'(e.expB));
        checkOutput("busy",    e.step, 32'(busy),    32'(e.expBusy));
        checkOutput("sat",     e.step, 32'(sat),     32'(e.expSat));
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    logic [15:0] wd;
    clr_n   = 1'b0;
    ld      = 1'b0;
    op      = OP_LOAD;
    waddr   = '0;
    wdata   = '0;
    raddr_a = '0;
    raddr_b = '0;
    flush   = 1'b0;
    modelReset();

    applyStimulus(1'b0, OP_LOAD, 0, 16'h0000, 0, 7, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_LOAD, 0, 16'h0000, 3, 4, 1'b0, 1'b0);

    // Read-old on a LOAD, then the new value.
    applyStimulus(1'b1, OP_LOAD, 3, 16'h1234, 3, 3, 1'b0, 1'b1);
    idle(3, 0);

    // Positive clamp, then sticky flag across an unclamped SUB.
    applyStimulus(1'b1, OP_LOAD, 0, 16'h7FF0, 0, 3, 1'b0, 1'b1);
    applyStimulus(1'b1, OP_ACC,  0, 16'h0020, 0, 3, 1'b0, 1'b1);
    applyStimulus(1'b1, OP_SUB,  0, 16'h0010, 0, 3, 1'b0, 1'b1);
    idle(0, 3);

    // Negative clamp, then ACC of -1 into an empty entry.
    applyStimulus(1'b1, OP_LOAD, 1, 16'h8005, 1, 2, 1'b0, 1'b1);
    applyStimulus(1'b1, OP_SUB,  1, 16'h0010, 1, 2, 1'b0, 1'b1);
    applyStimulus(1'b1, OP_ACC,  2, 16'hFFFF, 1, 2, 1'b0, 1'b1);
    idle(1, 2);

    // Dual read of one entry and CLEAR of a neighbour.
    applyStimulus(1'b1, OP_LOAD, 5, 16'h0555, 5, 5, 1'b0, 1'b1);
    applyStimulus(1'b1, OP_LOAD, 6, 16'h0666, 5, 5, 1'b0, 1'b1);
    applyStimulus(1'b1, OP_CLEAR, 6, 16'h1111, 6, 5, 1'b0, 1'b1);
    idle(6, 5);
    idle(3, 0);

    // Fill 1..8, flush, and try to write mid-sweep.
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b1, OP_LOAD, k, 16'(k + 1), k, 0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, OP_LOAD, 0, 16'h0000, 0, 7, 1'b1, 1'b1);
    for (int c = 0; c < DEPTH + 2; c++) begin
      applyStimulus(c == 4, OP_LOAD, 7, 16'h7777, c % DEPTH, (c + 4) % DEPTH, c == 2, 1'b1);
    end

    // Reset in the middle of a sweep, then LOAD right after release.
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b1, OP_LOAD, k, 16'(16'h0100 + k), k, 7 - k, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, OP_LOAD, 0, 16'h0000, 5, 6, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) idle(5, 6);
    applyStimulus(1'b0, OP_LOAD, 0, 16'h0000, 5, 6, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_LOAD, 2, 16'h2222, 2, 6, 1'b0, 1'b1);
    idle(2, 6);

    // Random traffic with extreme operands favoured.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       wd = 16'h7FFF;
        1:       wd = 16'h8000;
        default: wd = 16'($urandom);
      endcase
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                    int'($urandom_range(0, DEPTH - 1)), wd,
                    int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
                    $urandom_range(0, 24) == 0, $urandom_range(0, 79) != 0);
    end
    idle(0, 1);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
